// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package instruction_fetch_unit_pkg;

    localparam int unsigned IFU_DATA_WIDTH  = 32;
    localparam logic [31:0] IFU_RESET_PC    = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;
    localparam int unsigned PC_INCREMENT    = 4;

    // J/JAL target: upper PC+4 nibble, 26-bit word index from the instruction, word aligned.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: holds {instruction, PC+4, valid} for the decode stage.
// Latency: 1 cycle from capture to output.
// Backpressure: i_en low holds contents; i_flush (when enabled) loads a NOP bubble.
module instruction_fetch_unit_if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_instruction,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic [DATA_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_instruction;
    logic [DATA_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;

    // Capture fetched word, insert a bubble on flush, or hold when disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instruction <= DATA_WIDTH'(NOP_INSTRUCTION);
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
        end else if (i_en) begin
            if (i_flush) begin
                r_instruction <= DATA_WIDTH'(NOP_INSTRUCTION);
                r_pc_plus4    <= '0;
                r_valid       <= 1'b0;
            end else begin
                r_instruction <= i_instruction;
                r_pc_plus4    <= i_pc_plus4;
                r_valid       <= 1'b1;
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, next-PC select and IF/ID capture for the MIPS pipeline.
// Latency: Address is the PC (combinational); fetched word reaches IF/ID 1 cycle later.
// Backpressure: Stall holds PC and IF/ID; any redirect overrides Stall and inserts one bubble.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Jump,
    input  logic                  JumpRegister,
    input  logic [DATA_WIDTH-1:0] RegisterTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_jump_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_redirect;
    logic                  w_ifid_en;

    // Sequential increment wraps silently at the top of the address space.
    assign w_pc_plus4    = r_pc + DATA_WIDTH'(PC_INCREMENT);
    assign w_jump_target = jump_target(IFID_PCPlus4, IFID_Instruction);
    assign w_redirect    = JumpRegister | Jump | BranchTaken;
    // A redirect must flush IF/ID even while the hazard unit is stalling.
    assign w_ifid_en     = ~Stall | w_redirect;

    // Next-PC select: JR over J over branch over stall-hold over sequential; targets unmasked.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (JumpRegister) begin
            w_next_pc = RegisterTarget;
        end else if (Jump) begin
            w_next_pc = w_jump_target;
        end else if (BranchTaken) begin
            w_next_pc = BranchTarget;
        end else if (Stall) begin
            w_next_pc = r_pc;
        end
    end

    // Program counter register; reset drops any pending redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign Address = r_pc;

    instruction_fetch_unit_if_id_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .i_clk         (clk),
        .i_rst_n       (reset),
        .i_en          (w_ifid_en),
        .i_flush       (w_redirect),
        .i_instruction (Instruction),
        .i_pc_plus4    (w_pc_plus4),
        .o_instruction (IFID_Instruction),
        .o_pc_plus4    (IFID_PCPlus4),
        .o_valid       (IFID_Valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic        JumpRegister;
    logic [31:0] RegisterTarget;
    logic [31:0] Instruction;
    logic [31:0] Address;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic        jr;
        logic [31:0] rt;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc4;
        logic        exp_v;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
    } exp_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    exp_t sb [$];

    instruction_fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0040_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpRegister     (JumpRegister),
        .RegisterTarget   (RegisterTarget),
        .Instruction      (Instruction),
        .Address          (Address),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
    );

    // Program memory model: a j instruction at 0x0040_0004, address-derived words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0004) return 32'h0810_0010;
        return {~a[15:0], a[15:0]};
    endfunction

    assign Instruction = mem_word(Address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic vec_t mkv(input logic stall, input logic br, input logic [31:0] brt,
                                 input logic j, input logic jr, input logic [31:0] rt,
                                 input logic [31:0] ea, input logic [31:0] ep, input logic ev);
        vec_t v;
        v.stall = stall; v.br = br; v.brt = brt; v.j = j; v.jr = jr; v.rt = rt;
        v.exp_addr = ea; v.exp_pc4 = ep; v.exp_v = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] addr,
                            input logic [31:0] pc4, input logic v);
        exp_t e;
        e.name  = name;
        e.addr  = addr;
        e.pc4   = pc4;
        e.v     = v;
        e.instr = v ? mem_word(pc4 - 32'd4) : 32'h0;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
            return;
        end
        checks--;
        e = sb.pop_front();
        chk({e.name, ".Address"}, Address, e.addr);
        chk({e.name, ".IFID_Instruction"}, IFID_Instruction, e.instr);
        chk({e.name, ".IFID_PCPlus4"}, IFID_PCPlus4, e.pc4);
        chk({e.name, ".IFID_Valid"}, {31'd0, IFID_Valid}, {31'd0, e.v});
    endtask

    task automatic drive(input logic stall, input logic br, input logic [31:0] brt,
                         input logic j, input logic jr, input logic [31:0] rt);
        Stall = stall; BranchTaken = br; BranchTarget = brt;
        Jump = j; JumpRegister = jr; RegisterTarget = rt;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".Address"}, Address, 32'h0040_0000);
        chk({tag, ".IFID_Instruction"}, IFID_Instruction, 32'h0);
        chk({tag, ".IFID_PCPlus4"}, IFID_PCPlus4, 32'h0);
        chk({tag, ".IFID_Valid"}, {31'd0, IFID_Valid}, 32'h0);
    endtask

    initial begin
        vecs[0]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0004, 32'h0040_0004, 1);
        vecs[1]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0008, 32'h0040_0008, 1);
        vecs[2]  = mkv(1, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0008, 32'h0040_0008, 1);
        vecs[3]  = mkv(1, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0008, 32'h0040_0008, 1);
        vecs[4]  = mkv(0, 0, 32'h0,         1, 0, 32'h0,         32'h0040_0040, 32'h0,         0);
        vecs[5]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0044, 32'h0040_0044, 1);
        vecs[6]  = mkv(0, 1, 32'h0040_0020, 0, 0, 32'h0,         32'h0040_0020, 32'h0,         0);
        vecs[7]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0024, 32'h0040_0024, 1);
        vecs[8]  = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0028, 32'h0040_0028, 1);
        vecs[9]  = mkv(1, 1, 32'h0040_0020, 0, 1, 32'h0040_0100, 32'h0040_0100, 32'h0,         0);
        vecs[10] = mkv(1, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0100, 32'h0,         0);
        vecs[11] = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0104, 32'h0040_0104, 1);
        vecs[12] = mkv(1, 1, 32'h0040_0300, 1, 0, 32'h0,         32'h0BFC_0400, 32'h0,         0);
        vecs[13] = mkv(1, 1, 32'h0040_0010, 0, 0, 32'h0,         32'h0040_0010, 32'h0,         0);
        vecs[14] = mkv(0, 1, 32'h0040_0013, 0, 0, 32'h0,         32'h0040_0013, 32'h0,         0);
        vecs[15] = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0040_0017, 32'h0040_0017, 1);
        vecs[16] = mkv(0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         0);
        vecs[17] = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 1);
        vecs[18] = mkv(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0004, 32'h0000_0004, 1);

        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        // Reset held across clock edges keeps reset values.
        @(negedge clk);
        chk_reset_vals("reset_hold0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset_hold2");
        reset = 1'b1;

        // Table-driven pipeline vectors.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].j, vecs[i].jr, vecs[i].rt);
            push_exp($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_pc4, vecs[i].exp_v);
            @(posedge clk);
            #1;
            pop_cmp();
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle with a pending branch.
        drive(1, 1, 32'h0040_0500, 0, 0, 32'h0);
        #2 reset = 1'b0;
        #1 chk_reset_vals("async_reset");
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk);
        #1 chk_reset_vals("async_reset_edge");
        @(negedge clk);
        reset = 1'b1;

        // Restart: three edges reach 0x0040_000C with no leftover redirect.
        for (int k = 1; k <= 3; k++) begin
            push_exp($sformatf("restart%0d", k), 32'h0040_0000 + 32'(4 * k),
                     32'h0040_0000 + 32'(4 * k), 1);
            @(posedge clk);
            #1;
            pop_cmp();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
